uart_rx_cmd: RTL and testbench

- UART receiver for the motor-controller serial link; the receive side of the existing uartTx/TxDone transmit path.
- Frame: 8N1, LSB first, idle-high line.
- Converts the asynchronous rx line into bytes for the command decoder, using a valid/ack handshake.
- Detects false starts, framing errors and overrun.

---
 rtl/uart_rx_cmd.sv | 157 +++++++++++++++
 tb/tb_uart_rx_cmd.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: UART receiver (8N1, LSB first) with valid/ack byte handoff; define UART_RX_PARITY_EN for 8E1
module uart_rx_cmd #(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd5;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_q, tap_q;
    logic             rxf_q, rxf_prev_q, maj;
    logic [2:0]       state_q, state_d, bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d, data_q, data_d;
    logic             done_q, done_d, ferr_q, ferr_d, valid_q, valid_d, over_q, over_d;
    logic             wrap, par_ok, take;
`ifdef UART_RX_PARITY_EN
    logic             perr_q, perr_d, pbad_q, pbad_d;
    assign par_ok = !pbad_q;
`else
    assign par_ok = 1'b1;
`endif

    assign maj  = (sync_q[1] & tap_q[0]) | (sync_q[1] & tap_q[1]) | (tap_q[0] & tap_q[1]);
    assign wrap = cnt_q == LAST;

    // Two-flop synchroniser feeding a registered 3-tap majority vote; idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            tap_q      <= '1;
            rxf_q      <= 1'b1;
            rxf_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], rx_in};
            tap_q      <= {tap_q[0], sync_q[1]};
            rxf_q      <= maj;
            rxf_prev_q <= rxf_q;
        end
    end

    // Frame sequencing: start qualification, mid-bit sampling, stop/parity checks
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
        pbad_d  = pbad_q;
`endif
        case (state_q)
            IDLE:  if (rxf_prev_q && !rxf_q) state_d = START;
            START: if (cnt_q == HALF) begin
                state_d = rxf_q ? IDLE : DATA;
                bit_d   = 3'd0;
            end
            DATA:  if (wrap) begin
                shift_d = {rxf_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (wrap) begin
                pbad_d  = ^shift_q ^ rxf_q;
                perr_d  = pbad_d;
                state_d = STOP;
            end
`endif
            STOP:  if (wrap) begin
                state_d = rxf_q ? IDLE : BRK;
                done_d  = rxf_q & par_ok;
                ferr_d  = !rxf_q;
            end
            BRK:   if (rxf_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q || wrap) ? '0 : cnt_q + 1'b1;
    end

    // Hand the completed byte to the consumer; a held byte plus a new one without ack is an overrun
    always_comb begin
        take    = done_q && (!valid_q || rx_ack);
        valid_d = (valid_q && rx_ack) ? 1'b0 : valid_q;
        over_d  = (valid_q && rx_ack) ? 1'b0 : over_q;
        data_d  = take ? shift_q : data_q;
        valid_d = take ? 1'b1 : valid_d;
        over_d  = (done_q && !take) ? 1'b1 : over_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            over_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
            pbad_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            over_q  <= over_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
            pbad_q  <= pbad_d;
`endif
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = state_q != IDLE;
    assign frame_err = ferr_q;
    assign overrun   = over_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_cmd.sv
// tb_uart_rx_cmd: scoreboard bench for uart_rx_cmd at 16 clocks per bit
module tb_uart_rx_cmd;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, rx_in = 1'b1, rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err, overrun, parity_err;

    uart_rx_cmd #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    typedef struct { int k; logic [7:0] d; } ev_t;
    ev_t  q[$];
    int   checks = 0, errors = 0;
    bit   model_held = 1'b0, exp_over = 1'b0;
    logic pv = 1'b0, pack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input int k, input logic [7:0] d);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected none", k, d);
        end else begin
            e = q.pop_front();
            if (e.k != k || e.d !== d) begin
                errors++;
                $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h", k, d, e.k, e.d);
            end
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        ev_t e;
        e.k = k;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model(input logic [7:0] b, input bit stop, input bit pflip, input bit ackdel);
        bit pok;
        pok = !(PAR && pflip);
        if (!pok) push(2, 8'h00);
        if (!stop) push(1, 8'h00);
        else if (pok) begin
            if (model_held && !ackdel) exp_over = 1'b1;
            else begin
                push(0, b);
                model_held = 1'b1;
                if (ackdel) exp_over = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stop, input bit pflip);
        logic [10:0] v;
        v = PAR ? {stop, ^b ^ pflip, b, 1'b0} : {1'b1, stop, b, 1'b0};
        for (int i = 0; i < (PAR ? 11 : 10); i++) begin
            rx_in = v[i];
            idle(CPB);
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit stop, input bit pflip);
        model(b, stop, pflip, 1'b0);
        send(b, stop, pflip);
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        idle(1);
        rx_ack = 1'b0;
        model_held = 1'b0;
        exp_over = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) pop_check(1, 8'h00);
            if (parity_err) pop_check(2, 8'h00);
            if (rx_valid && (!pv || pack)) pop_check(0, rx_data);
        end
        pv   = rx_valid;
        pack = rx_ack;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit ok, seen, stp, pf;
        int n;
        idle(3);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_flags", {frame_err, overrun, parity_err}, 0);
        rst_n = 1'b1;
        idle(10);
        chk("post_rst_busy", rx_busy, 0);

        frame(8'hA5, 1'b1, 1'b0);
        idle(2);
        chk("t1_valid", rx_valid, 1);
        chk("t1_data", rx_data, 8'hA5);
        ok = 1'b1;
        repeat (100) begin
            idle(1);
            ok &= rx_valid && rx_data == 8'hA5;
        end
        chk("t1_hold", ok, 1);
        do_ack();
        chk("t1_ack", rx_valid, 0);

        rx_in = 1'b0;
        idle(1);
        rx_in = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            idle(1);
            seen |= rx_busy;
        end
        chk("t2_glitch", seen, 0);
        rx_in = 1'b0;
        idle(5);
        rx_in = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            idle(1);
            seen |= rx_busy;
        end
        chk("t2_start_seen", seen, 1);
        chk("t2_back_idle", rx_busy, 0);
        chk("t2_flags", {rx_valid, overrun}, 0);

        frame(8'h3C, 1'b0, 1'b0);
        idle(40);
        chk("t3_brk_busy", rx_busy, 1);
        chk("t3_valid", rx_valid, 0);
        rx_in = 1'b1;
        idle(10);
        chk("t3_brk_exit", rx_busy, 0);
        frame(8'h81, 1'b1, 1'b0);
        idle(2);
        chk("t3_next", rx_data, 8'h81);
        do_ack();

        frame(8'h11, 1'b1, 1'b0);
        frame(8'h22, 1'b1, 1'b0);
        idle(3);
        chk("t4_data", rx_data, 8'h11);
        chk("t4_overrun", overrun, exp_over);
        chk("t4_valid", rx_valid, 1);
        do_ack();
        chk("t4_ack", {rx_valid, overrun}, 0);

        frame(8'h11, 1'b1, 1'b0);
        idle(3);
        model(8'h22, 1'b1, 1'b0, 1'b1);
        fork
            send(8'h22, 1'b1, 1'b0);
            begin
                n = 0;
                while (!rx_busy && n < 50) begin
                    idle(1);
                    n++;
                end
                chk("t5_busy_rise", rx_busy, 1);
                n = 0;
                while (rx_busy && n < 300) begin
                    idle(1);
                    n++;
                end
                chk("t5_busy_fall", rx_busy, 0);
                rx_ack = 1'b1;
                idle(1);
                rx_ack = 1'b0;
            end
        join
        idle(2);
        chk("t5_data", rx_data, 8'h22);
        chk("t5_valid", rx_valid, 1);
        chk("t5_overrun", overrun, exp_over);
        do_ack();

        frame(8'h77, 1'b1, 1'b0);
        idle(3);
        rx_in = 1'b0;
        idle(CPB);
        rx_in = 1'b1;
        idle(CPB * 4 + CPB / 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out", {rx_data, rx_valid, rx_busy, frame_err, overrun, parity_err}, 0);
        model_held = 1'b0;
        exp_over = 1'b0;
        idle(5);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (CPB * 12) begin
            idle(1);
            seen |= rx_busy | rx_valid;
        end
        chk("t6_no_spurious", seen, 0);
        frame(8'h5A, 1'b1, 1'b0);
        idle(2);
        chk("t6_next", {rx_valid, rx_data}, {1'b1, 8'h5A});
        do_ack();
`ifdef UART_RX_PARITY_EN
        frame(8'h5A, 1'b1, 1'b1);
        idle(2);
        chk("t6_parity_drop", rx_valid, 0);
`endif

        for (int i = 0; i < 24; i++) begin
            stp = $urandom_range(0, 5) != 0;
            pf  = PAR && $urandom_range(0, 5) == 0;
            frame(8'($urandom), stp, pf);
            rx_in = 1'b1;
            idle($urandom_range(6, 12));
            chk("rand_valid", rx_valid, model_held);
            if (rx_valid) do_ack();
        end

        idle(20);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
